mul_radix4_seq: RTL and testbench

- Sequential controller for the 64x64 signed radix-4 Booth multiplier.
- Holds the 128-bit partial-product/multiplier register and the Booth history bit, and selects each 3-bit Booth group.
- Instantiates `cal_radix4` as the combinational step: one `cal_radix4` step per clock, 32 steps per product.
- Sits between the bus/command wrapper (op_start/op_clear) and `cal_radix4`; produces the final signed 128-bit product.

---
 rtl/mul_radix4_seq.sv | 137 +++++++++++++
 tb/tb_mul_radix4_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_radix4_seq.sv
// mul_radix4_seq: sequential signed radix-4 Booth multiplier, one cal_radix4 step per clock.
// Optional macro MUL_EARLY_TERM_EN collapses trailing shift-only Booth groups into one clock.

module cal_radix4 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [2:0]         last_3bits,
  input  logic [2*WIDTH-1:0] result_in,
  output logic [2*WIDTH-1:0] result_out
);
  localparam int EW = 2*WIDTH + 2;

  // Two guard bits keep acc +/- 2M exact before the shift, even for most-negative operands.
  logic signed [EW-1:0] acc_x, m1_x, m2_x, sum_x;

  always_comb begin
    acc_x = {{2{result_in[2*WIDTH-1]}}, result_in};
    m1_x  = {{2{multiplier[WIDTH-1]}}, multiplier, {WIDTH{1'b0}}};
    m2_x  = {multiplier[WIDTH-1], multiplier, {(WIDTH+1){1'b0}}};
    case (last_3bits)
      3'b001, 3'b010: sum_x = acc_x + m1_x;
      3'b011:         sum_x = acc_x + m2_x;
      3'b100:         sum_x = acc_x - m2_x;
      3'b101, 3'b110: sum_x = acc_x - m1_x;
      default:        sum_x = acc_x;
    endcase
    result_out = (2*WIDTH)'(sum_x >>> 2);
  end
endmodule

module mul_radix4_seq #(
  parameter int WIDTH = 64,
  parameter int STEPS = WIDTH/2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, step_out, acc_exec;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic               q_m1;
  logic               exec_last;

  cal_radix4 #(.WIDTH(WIDTH)) u_step (
    .multiplier (mcand),
    .last_3bits ({acc[1:0], q_m1}),
    .result_in  (acc),
    .result_out (step_out)
  );

`ifdef MUL_EARLY_TERM_EN
  localparam int SW = $clog2(WIDTH + 2);

  logic [SW-1:0] live_bits, skip_sh;
  logic [WIDTH:0] live_mask, hist;
  logic           skip;

  // Unconsumed multiplier bits plus history: if uniform, every remaining group is 000/111.
  always_comb begin
    live_bits = SW'(WIDTH + 1) - SW'({cnt, 1'b0});
    live_mask = (WIDTH+1)'(((WIDTH+2)'(1) << live_bits) - (WIDTH+2)'(1));
    hist      = {acc[WIDTH-1:0], q_m1};
    skip      = ((hist & live_mask) == '0) || ((hist & live_mask) == live_mask);
    skip_sh   = SW'(2*STEPS) - SW'({cnt, 1'b0});
    acc_exec  = skip ? (2*WIDTH)'($signed(acc) >>> skip_sh) : step_out;
    exec_last = skip || (cnt == CW'(STEPS-1));
  end
`else
  always_comb begin
    acc_exec  = step_out;
    exec_last = (cnt == CW'(STEPS-1));
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset || op_clear) state <= IDLE;
    else                   state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (op_start)  state_nxt = EXEC;
      EXEC:       if (exec_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so they carry no input-to-output path.
  always_comb begin
    op_busy = (state == EXEC);
    op_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      acc    <= '0;
      q_m1   <= 1'b0;
      mcand  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (op_start) begin
            mcand <= multiplicand;
            acc   <= {{WIDTH{1'b0}}, multiplier};
            q_m1  <= 1'b0;
            cnt   <= '0;
          end
        end
        EXEC: begin
          acc  <= acc_exec;
          q_m1 <= acc[1];
          cnt  <= cnt + CW'(1);
          if (exec_last) result <= acc_exec;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_radix4_seq.sv
// Directed bench for mul_radix4_seq: vector table of signed products plus clear/restart/start-ignore sequences.
// Latency expectations follow MUL_EARLY_TERM_EN when the bench is built with it.

module tb_mul_radix4_seq;
  logic         clk = 1'b0;
  logic         reset, op_start, op_clear;
  logic [63:0]  multiplicand, multiplier;
  logic         op_busy, op_done;
  logic [127:0] result;

  int n_pass  = 0;
  int n_total = 0;

  mul_radix4_seq #(.WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_busy      (op_busy),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  mc;
    logic [63:0]  mp;
    logic [127:0] prod;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_lat(input string name, input int cyc);
`ifdef MUL_EARLY_TERM_EN
    chk(name, 128'(cyc >= 1 && cyc <= 32), 128'd1);
`else
    chk(name, 128'(cyc), 128'd32);
`endif
  endtask

  // Start a product, then count edges after the start edge until op_done (bounded).
  task automatic run_mul(input logic [63:0] mc, input logic [63:0] mp,
                         output logic [127:0] res, output int cyc,
                         output int busy_cyc, output logic done0);
    @(negedge clk);
    multiplicand = mc;
    multiplier   = mp;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    done0    = op_done;
    cyc      = 0;
    busy_cyc = 0;
    while (!op_done && cyc < 100) begin
      if (op_busy) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    res = result;
  endtask

  initial begin
    logic [127:0] res;
    int           cyc, busy_cyc;
    logic         done0;

    reset = 1'b1; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = '0; multiplier = '0;

    vecs[0]  = '{64'd3, 64'd5, 128'h0F};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'h1};
    vecs[2]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 128'h4000_0000_0000_0000_0000_0000_0000_0000};
    vecs[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                 128'hC000_0000_0000_0000_8000_0000_0000_0000};
    vecs[4]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFA,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6};
    vecs[5]  = '{64'd0, 64'd12345, 128'h0};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd3,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
    vecs[7]  = '{64'h8000_0000_0000_0000, 64'd1,
                 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
    vecs[8]  = '{64'd1, 64'h8000_0000_0000_0000,
                 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
    vecs[9]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
    vecs[10] = '{64'h1234_5678_9ABC_DEF0, 64'h10,
                 128'h0000_0000_0000_0001_2345_6789_ABCD_EF00};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                 128'h0000_0000_0000_0000_8000_0000_0000_0000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   128'(op_busy), 128'd0);
    chk("reset_done",   128'(op_done), 128'd0);
    chk("reset_result", result,        128'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_mul(vecs[i].mc, vecs[i].mp, res, cyc, busy_cyc, done0);
      chk($sformatf("prod[%0d]", i), res, vecs[i].prod);
      chk_lat($sformatf("latency[%0d]", i), cyc);
      chk($sformatf("busy_cycles[%0d]", i), 128'(busy_cyc), 128'(cyc));
    end

    // DONE holds its result until something new happens
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done",   128'(op_done), 128'd1);
    chk("hold_result", result,        vecs[11].prod);

    // Clear at step 10 of EXEC aborts with no residue
    @(negedge clk);
    multiplicand = 64'h7FFF_FFFF_FFFF_FFFF;
    multiplier   = 64'h8000_0000_0000_0000;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_clear_busy", 128'(op_busy), 128'd1);
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk); #1;
    op_clear = 1'b0;
    chk("clear_busy",   128'(op_busy), 128'd0);
    chk("clear_done",   128'(op_done), 128'd0);
    chk("clear_result", result,        128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_stays_idle", 128'({op_busy, op_done}), 128'd0);
    run_mul(64'd7, 64'hFFFF_FFFF_FFFF_FFFA, res, cyc, busy_cyc, done0);
    chk("after_clear_prod", res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    chk_lat("after_clear_latency", cyc);

    // op_start pulsed mid-EXEC is ignored
    @(negedge clk);
    multiplicand = 64'd3;
    multiplier   = 64'd5;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    cyc = 0;
    while (!op_done && cyc < 100) begin
      op_start = (cyc == 4);
      if (cyc == 4) begin
        multiplicand = 64'd100;
        multiplier   = 64'd100;
      end
      @(posedge clk); #1;
      cyc++;
    end
    op_start = 1'b0;
    chk("ignore_start_prod", result, 128'h0F);
    chk_lat("ignore_start_latency", cyc);

    // Restart straight from DONE
    run_mul(64'd0, 64'd12345, res, cyc, busy_cyc, done0);
    chk("restart_done_drops", 128'(done0), 128'd0);
    chk("restart_prod", res, 128'd0);
    chk_lat("restart_latency", cyc);

    // Start and clear together: clear wins
    @(negedge clk);
    multiplicand = 64'd3;
    multiplier   = 64'd5;
    op_start     = 1'b1;
    op_clear     = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    op_clear = 1'b0;
    chk("start_clear_busy",   128'(op_busy), 128'd0);
    chk("start_clear_done",   128'(op_done), 128'd0);
    chk("start_clear_result", result,        128'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("start_clear_idle", 128'({op_busy, op_done}), 128'd0);

    // Small multiplier: early termination shortens latency only when enabled
    run_mul(64'd9, 64'd4, res, cyc, busy_cyc, done0);
    chk("small_prod", res, 128'd36);
`ifdef MUL_EARLY_TERM_EN
    chk("small_latency_short", 128'(cyc < 32), 128'd1);
`else
    chk("small_latency", 128'(cyc), 128'd32);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
